bitwise_logic_unit: RTL and testbench
=====================================

# bitwise_logic_unit

Parametrised, registered bitwise logic unit. It replaces the fixed 8-bit AND8/OR8/XOR8/NOT8 instances with one WIDTH-bit datapath that offers 8 selectable operations, a valid/ready handshake, result flags and an optional accumulator. It sits between the operand source (register file or test driver) and any downstream consumer that needs a stallable, one-cycle-latency logic result.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 1 to 64.
- CNT_WIDTH, 16: width of the completed-operation counter.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  operands and op are valid this cycle.
- IN_READY  out  1  unit accepts a transaction this cycle.
- OP  in  3  operation select: 000 AND, 001 OR, 010 XOR, 011 NOT A, 100 NAND, 101 NOR, 110 XNOR, 111 PASS A.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B; ignored by NOT A and PASS A.
- USE_ACC  in  1  substitute the accumulator for B (only with BLU_ACC_EN).
- ACC_CLR  in  1  clear the accumulator (only with BLU_ACC_EN).
- OUT_VALID  out  1  F and the flags hold a result.
- OUT_READY  in  1  consumer takes the result this cycle.
- F  out  WIDTH  registered result.
- ZERO  out  1  F is all zeros.
- PARITY  out  1  XOR-reduction of F.
- OP_COUNT  out  CNT_WIDTH  number of results consumed since reset.

## Operation
- Accept: IN_VALID && IN_READY. IN_READY = RST_N && (!OUT_VALID || OUT_READY). This is a combinational pass-through of OUT_READY.
- On accept, the unit computes F_next = OP(A, B_eff) bitwise, where B_eff = (USE_ACC ? ACC : B). It registers F_next, ZERO = (F_next == 0) and PARITY = ^F_next, and sets OUT_VALID=1.
- Output consume: OUT_VALID && OUT_READY. If there is no accept in the same cycle, OUT_VALID goes to 0 and F, ZERO and PARITY hold their values.
- Simultaneous consume and accept: the new result replaces the old one with no bubble, OUT_VALID stays 1, and full throughput is one transaction per cycle.
- While OUT_VALID && !OUT_READY, F, ZERO, PARITY and OUT_VALID hold stable and IN_READY=0.
- OP_COUNT increments by 1 on every consume. It wraps from 2^CNT_WIDTH-1 to 0 without any flag.
- Accumulator (only with BLU_ACC_EN):
  - On every accept with USE_ACC=1, ACC <= F_next.
  - ACC_CLR=1 sets ACC <= 0 regardless of the handshake, and it takes priority over the update.
  - An accept in the same cycle as ACC_CLR still uses the old ACC as B_eff.
  - ACC is not a port; it is observable only through F.
- Reset (asynchronous assert, synchronous release):
  - F=0, ZERO=0, PARITY=0, OUT_VALID=0, OP_COUNT=0, ACC=0, IN_READY=0.
  - A pending result is discarded when reset asserts mid-transaction.
  - IN_READY rises combinationally when RST_N deasserts.

## Timing
- Latency is 1 cycle: a result accepted at edge N is visible on F with OUT_VALID=1 after edge N.
- Throughput is 1 per cycle while OUT_READY=1.
- The combinational paths are OUT_READY -> IN_READY and RST_N -> IN_READY only. A and B reach F only through the register.

## Configuration
- BLU_ACC_EN defined:
  - The ACC register exists and USE_ACC and ACC_CLR are functional.
- BLU_ACC_EN undefined:
  - There is no ACC register.
  - USE_ACC and ACC_CLR remain ports but are ignored, so B_eff = B.
  - All other behaviour is identical.

## Structure
- Shared package bitwise_pkg holds:
  - the 3-bit op encoding constants OP_AND, OP_OR, OP_XOR, OP_NOTA, OP_NAND, OP_NOR, OP_XNOR and OP_PASSA;
  - the op_t typedef.
- Sub-module blu_bit_op is a one-bit combinational slice: inputs A, B and OP, output F, built from nand primitives like the existing gate cells. The top instantiates it WIDTH times with a generate loop.
- The top holds the handshake, output register, flag logic, counter and ACC.

## Test plan
- Reset, then for each op 000..111 with WIDTH=8, A=8'hC5, B=8'h3A, OUT_READY=1 -> F = 00, FF, FF, 3A, FF, 00, 00, C5 one cycle after each accept. ZERO=1 for AND/NOR/XNOR, PARITY=0 for all.
- Back-to-back accepts with OUT_READY=1 for 10 cycles -> OUT_VALID continuously 1, F changes every cycle, OP_COUNT=10.
- Backpressure: accept XOR A=8'h0F, B=8'h01 (F=8'h0E), then hold OUT_READY=0 for 3 cycles with new IN_VALID -> IN_READY=0, F stays 0E, PARITY=1. Release -> the next result follows on the next cycle.
- BLU_ACC_EN: ACC_CLR, then OR with USE_ACC=1 on A=01, 02, 04 -> F = 01, 03, 07. ACC_CLR together with an accept of A=08 -> F=0F and the next USE_ACC OR with A=10 gives F=10.
- Counter wrap: CNT_WIDTH=4, 17 consumes -> OP_COUNT=1.
- Assert RST_N low while OUT_VALID=1 and OUT_READY=0 -> all outputs go to their reset values immediately. After release, the first accept produces the correct result with no stale data.

Source files
------------

// File: rtl/bitwise_pkg.sv
// Shared operation encodings for the bitwise logic unit and its bit slice.
package bitwise_pkg;

   typedef enum logic [2:0] {
      OP_AND   = 3'b000,
      OP_OR    = 3'b001,
      OP_XOR   = 3'b010,
      OP_NOTA  = 3'b011,
      OP_NAND  = 3'b100,
      OP_NOR   = 3'b101,
      OP_XNOR  = 3'b110,
      OP_PASSA = 3'b111
   } op_t;

   // The upper four ops are the bitwise complements of the lower four.
   localparam int unsigned OP_SEL_LO = 0;
   localparam int unsigned OP_SEL_HI = 1;
   localparam int unsigned OP_INVERT = 2;

endpackage

// File: rtl/blu_bit_op.sv
// One-bit combinational logic slice built only from two-input nand cells.
module blu_bit_op
   import bitwise_pkg::*;
(
   input  logic       A,
   input  logic       B,
   input  logic [2:0] OP,
   output logic       F
);

   logic s0, s1, s2, ns0, ns1;
   logic n_ab, n_a, n_b, f_and, f_or, x_a, x_b, f_xor;
   logic m0a, m0b, m_lo, m1a, m1b, m_hi, m2a, m2b, base;
   logic inv_n, inv_a, inv_b;

   assign s0 = OP[OP_SEL_LO];
   assign s1 = OP[OP_SEL_HI];
   assign s2 = OP[OP_INVERT];

   nand g_ns0  (ns0,   s0,    s0);
   nand g_ns1  (ns1,   s1,    s1);

   nand g_nab  (n_ab,  A,     B);
   nand g_na   (n_a,   A,     A);
   nand g_nb   (n_b,   B,     B);
   nand g_and  (f_and, n_ab,  n_ab);
   nand g_or   (f_or,  n_a,   n_b);
   nand g_xa   (x_a,   A,     n_ab);
   nand g_xb   (x_b,   B,     n_ab);
   nand g_xor  (f_xor, x_a,   x_b);

   // 4:1 select on OP[1:0]: AND / OR / XOR / NOT A (n_a)
   nand g_m0a  (m0a,   f_or,  s0);
   nand g_m0b  (m0b,   f_and, ns0);
   nand g_mlo  (m_lo,  m0a,   m0b);
   nand g_m1a  (m1a,   n_a,   s0);
   nand g_m1b  (m1b,   f_xor, ns0);
   nand g_mhi  (m_hi,  m1a,   m1b);
   nand g_m2a  (m2a,   m_hi,  s1);
   nand g_m2b  (m2b,   m_lo,  ns1);
   nand g_base (base,  m2a,   m2b);

   // Conditional inversion by OP[2] (nand-built xor)
   nand g_invn (inv_n, base,  s2);
   nand g_inva (inv_a, base,  inv_n);
   nand g_invb (inv_b, s2,    inv_n);
   nand g_f    (F,     inv_a, inv_b);

endmodule

// File: rtl/bitwise_logic_unit.sv
// Registered WIDTH-bit logic unit with valid/ready handshake, flags and counter.
// Optional accumulator enabled by defining BLU_ACC_EN.
module bitwise_logic_unit
   import bitwise_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic [2:0]           OP,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic                 USE_ACC,
   input  logic                 ACC_CLR,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [WIDTH-1:0]     F,
   output logic                 ZERO,
   output logic                 PARITY,
   output logic [CNT_WIDTH-1:0] OP_COUNT
);

   op_t                  op_sel;
   logic [WIDTH-1:0]     b_eff;
   logic [WIDTH-1:0]     f_next;
   logic [WIDTH-1:0]     f_q;
   logic                 zero_q;
   logic                 parity_q;
   logic                 valid_q;
   logic [CNT_WIDTH-1:0] count_q;
   logic                 accept;
   logic                 consume;

   assign op_sel   = op_t'(OP);
   assign IN_READY = RST_N && (!valid_q || OUT_READY);
   assign accept   = IN_VALID && IN_READY;
   assign consume  = valid_q && OUT_READY;

`ifdef BLU_ACC_EN
   logic [WIDTH-1:0] acc_q;

   assign b_eff = USE_ACC ? acc_q : B;

   // Clear wins over update; a same-cycle accept already used the old value.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         acc_q <= '0;
      end else if (ACC_CLR) begin
         acc_q <= '0;
      end else if (accept && USE_ACC) begin
         acc_q <= f_next;
      end
   end
`else
   logic unused_acc_ports;

   assign b_eff            = B;
   assign unused_acc_ports = USE_ACC ^ ACC_CLR;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      blu_bit_op u_bit (
         .A  (A[i]),
         .B  (b_eff[i]),
         .OP (op_sel),
         .F  (f_next[i])
      );
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         f_q      <= '0;
         zero_q   <= 1'b0;
         parity_q <= 1'b0;
         valid_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         if (accept) begin
            f_q      <= f_next;
            zero_q   <= ~|f_next;
            parity_q <= ^f_next;
            valid_q  <= 1'b1;
         end else if (consume) begin
            valid_q  <= 1'b0;
         end
         if (consume) begin
            count_q <= count_q + CNT_WIDTH'(1);
         end
      end
   end

   assign F         = f_q;
   assign ZERO      = zero_q;
   assign PARITY    = parity_q;
   assign OUT_VALID = valid_q;
   assign OP_COUNT  = count_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Scoreboard bench for bitwise_logic_unit (default and CNT_WIDTH=4 instances).
module tb_bitwise_logic_unit;
   import bitwise_pkg::*;

   typedef struct packed {
      logic [7:0] f;
      logic       zero;
      logic       parity;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [2:0]  op = '0;
   logic [7:0]  a = '0;
   logic [7:0]  b = '0;
   logic        use_acc = 1'b0;
   logic        acc_clr = 1'b0;
   logic        out_ready = 1'b0;
   logic        in_ready, out_valid, zero, parity;
   logic [7:0]  f;
   logic [15:0] op_count;
   logic        unused_in_ready4, unused_out_valid4, unused_zero4, unused_parity4;
   logic [7:0]  unused_f4;
   logic [3:0]  op_count4;

   res_t        sb[$];
   res_t        last_r = '0;
   res_t        exp_r;
   logic        exp_valid;
   logic [7:0]  acc_m = '0;
   int unsigned cons_total = 0;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   bitwise_logic_unit #(.WIDTH(8), .CNT_WIDTH(16)) dut (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
      .OP(op), .A(a), .B(b), .USE_ACC(use_acc), .ACC_CLR(acc_clr),
      .OUT_VALID(out_valid), .OUT_READY(out_ready), .F(f), .ZERO(zero),
      .PARITY(parity), .OP_COUNT(op_count)
   );

   bitwise_logic_unit #(.WIDTH(8), .CNT_WIDTH(4)) dut_c4 (
      .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(unused_in_ready4),
      .OP(op), .A(a), .B(b), .USE_ACC(use_acc), .ACC_CLR(acc_clr),
      .OUT_VALID(unused_out_valid4), .OUT_READY(out_ready), .F(unused_f4),
      .ZERO(unused_zero4), .PARITY(unused_parity4), .OP_COUNT(op_count4)
   );

   function automatic res_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      res_t r;
      case (op_t'(o))
         OP_AND:   r.f = x & y;
         OP_OR:    r.f = x | y;
         OP_XOR:   r.f = x ^ y;
         OP_NOTA:  r.f = ~x;
         OP_NAND:  r.f = ~(x & y);
         OP_NOR:   r.f = ~(x | y);
         OP_XNOR:  r.f = ~(x ^ y);
         default:  r.f = x;
      endcase
      r.zero   = (r.f == 8'h00);
      r.parity = ^r.f;
      return r;
   endfunction

   task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] aa,
                        input logic [7:0] bb, input logic ua, input logic ac, input logic rdy);
      @(negedge clk);
      in_valid = v; op = o; a = aa; b = bb; use_acc = ua; acc_clr = ac; out_ready = rdy;
      #1;
   endtask

   // Advance the reference model across the next rising edge.
   task automatic advance();
      logic       acc_now, cons_now;
      logic [7:0] beff;
      res_t       r;
      r        = '0;
      cons_now = rst_n && (sb.size() != 0) && out_ready;
      acc_now  = in_valid && rst_n && ((sb.size() == 0) || out_ready);
      beff     = b;
`ifdef BLU_ACC_EN
      if (use_acc) beff = acc_m;
`endif
      if (cons_now) begin
         last_r = sb.pop_front();
         cons_total++;
      end
      if (acc_now) begin
         r = model(op, a, beff);
         sb.push_back(r);
      end
`ifdef BLU_ACC_EN
      if (acc_clr) acc_m = '0;
      else if (acc_now && use_acc) acc_m = r.f;
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({out_valid, in_ready, f, zero, parity} !== 11'b0 || op_count !== 16'd0 || op_count4 !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_state: valid=%b ready=%b f=%h z=%b p=%b cnt=%0d cnt4=%0d, want all zero",
                  out_valid, in_ready, f, zero, parity, op_count, op_count4);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_ops();
      logic [7:0] tbl [8];
      tbl = '{8'h00, 8'hFF, 8'hFF, 8'h3A, 8'hFF, 8'h00, 8'h00, 8'hC5};
      for (int k = 0; k < 9; k++) begin
         if (k < 8) drive(1'b1, 3'(k), 8'hC5, 8'h3A, 1'b0, 1'b0, 1'b1);
         else       drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
         exp_valid = (sb.size() != 0);
         exp_r = exp_valid ? sb[0] : last_r;
         vectors++;
         if (out_valid !== exp_valid || in_ready !== 1'b1 || {f, zero, parity} !== exp_r) begin
            miscompares++;
            $display("FAIL ops_scoreboard[%0d]: valid=%b ready=%b f=%h z=%b p=%b, want valid=%b ready=1 f=%h z=%b p=%b",
                     k, out_valid, in_ready, f, zero, parity, exp_valid, exp_r.f, exp_r.zero, exp_r.parity);
         end
         advance();
         if (k < 8) begin
            vectors++;
            if (out_valid !== 1'b1 || f !== tbl[k] || zero !== (tbl[k] == 8'h00) || parity !== 1'b0) begin
               miscompares++;
               $display("FAIL ops_table[%0d]: valid=%b f=%h z=%b p=%b, want valid=1 f=%h z=%b p=0",
                        k, out_valid, f, zero, parity, tbl[k], (tbl[k] == 8'h00));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int unsigned c0;
      c0 = cons_total;
      for (int k = 0; k < 11; k++) begin
         if (k < 10) drive(1'b1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1);
         else        drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
         exp_valid = (sb.size() != 0);
         exp_r = exp_valid ? sb[0] : last_r;
         vectors++;
         if (out_valid !== exp_valid || in_ready !== 1'b1 || {f, zero, parity} !== exp_r
             || op_count !== cons_total[15:0]) begin
            miscompares++;
            $display("FAIL b2b[%0d]: valid=%b ready=%b f=%h z=%b p=%b cnt=%0d, want valid=%b ready=1 f=%h z=%b p=%b cnt=%0d",
                     k, out_valid, in_ready, f, zero, parity, op_count,
                     exp_valid, exp_r.f, exp_r.zero, exp_r.parity, cons_total[15:0]);
         end
         advance();
      end
      vectors++;
      if (op_count !== 16'(c0 + 10)) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d want %0d", op_count, c0 + 10);
      end
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < 7; k++) begin
         case (k)
            0:       drive(1'b1, OP_XOR, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);
            1, 2, 3: drive(1'b1, OP_AND, 8'hF3, 8'h3C, 1'b0, 1'b0, 1'b0);
            4:       drive(1'b1, OP_AND, 8'hF3, 8'h3C, 1'b0, 1'b0, 1'b1);
            default: drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
         endcase
         exp_valid = (sb.size() != 0);
         exp_r = exp_valid ? sb[0] : last_r;
         vectors++;
         if (out_valid !== exp_valid || in_ready !== (!exp_valid || out_ready)
             || {f, zero, parity} !== exp_r || op_count !== cons_total[15:0]) begin
            miscompares++;
            $display("FAIL bp[%0d]: valid=%b ready=%b f=%h z=%b p=%b cnt=%0d, want valid=%b ready=%b f=%h z=%b p=%b cnt=%0d",
                     k, out_valid, in_ready, f, zero, parity, op_count, exp_valid,
                     (!exp_valid || out_ready), exp_r.f, exp_r.zero, exp_r.parity, cons_total[15:0]);
         end
         if (k >= 1 && k <= 3) begin
            vectors++;
            if (in_ready !== 1'b0 || f !== 8'h0E || parity !== 1'b1 || out_valid !== 1'b1) begin
               miscompares++;
               $display("FAIL bp_stall[%0d]: ready=%b f=%h p=%b valid=%b, want ready=0 f=0e p=1 valid=1",
                        k, in_ready, f, parity, out_valid);
            end
         end
         advance();
      end
   endtask

   task automatic test_acc();
      logic [7:0] av [7];
      av = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h00};
      for (int k = 0; k < 7; k++) begin
         case (k)
            0:       drive(1'b0, OP_OR, av[k], 8'h40, 1'b0, 1'b1, 1'b1);
            4:       drive(1'b1, OP_OR, av[k], 8'h40, 1'b1, 1'b1, 1'b1);
            6:       drive(1'b0, OP_OR, av[k], 8'h40, 1'b0, 1'b0, 1'b1);
            default: drive(1'b1, OP_OR, av[k], 8'h40, 1'b1, 1'b0, 1'b1);
         endcase
         exp_valid = (sb.size() != 0);
         exp_r = exp_valid ? sb[0] : last_r;
         vectors++;
         if (out_valid !== exp_valid || {f, zero, parity} !== exp_r) begin
            miscompares++;
            $display("FAIL acc[%0d]: valid=%b f=%h z=%b p=%b, want valid=%b f=%h z=%b p=%b",
                     k, out_valid, f, zero, parity, exp_valid, exp_r.f, exp_r.zero, exp_r.parity);
         end
         advance();
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, OP_AND, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0);
      advance();
      drive(1'b0, OP_AND, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (out_valid !== 1'b1 || f !== 8'h0F) begin
         miscompares++;
         $display("FAIL rst_mid_pending: valid=%b f=%h, want valid=1 f=0f", out_valid, f);
      end
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({out_valid, in_ready, f, zero, parity} !== 11'b0 || op_count !== 16'd0 || op_count4 !== 4'd0) begin
         miscompares++;
         $display("FAIL rst_mid_clear: valid=%b ready=%b f=%h z=%b p=%b cnt=%0d, want all zero",
                  out_valid, in_ready, f, zero, parity, op_count);
      end
      sb.delete();
      last_r = '0;
      acc_m = '0;
      cons_total = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) drive(1'b1, OP_XOR, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b1);
         else        drive(1'b0, OP_XOR, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
         exp_valid = (sb.size() != 0);
         exp_r = exp_valid ? sb[0] : last_r;
         vectors++;
         if (out_valid !== exp_valid || in_ready !== 1'b1 || {f, zero, parity} !== exp_r) begin
            miscompares++;
            $display("FAIL rst_mid_after[%0d]: valid=%b ready=%b f=%h, want valid=%b ready=1 f=%h",
                     k, out_valid, in_ready, f, exp_valid, exp_r.f);
         end
         advance();
      end
      vectors++;
      if (op_count !== 16'd1) begin
         miscompares++;
         $display("FAIL rst_mid_count: got %0d want 1", op_count);
      end
   endtask

   task automatic test_wrap();
      int unsigned c0;
      c0 = cons_total;
      for (int k = 0; k < 18; k++) begin
         drive(k < 17, OP_PASSA, 8'(k), 8'h00, 1'b0, 1'b0, 1'b1);
         exp_valid = (sb.size() != 0);
         exp_r = exp_valid ? sb[0] : last_r;
         vectors++;
         if (out_valid !== exp_valid || {f, zero, parity} !== exp_r || op_count4 !== cons_total[3:0]) begin
            miscompares++;
            $display("FAIL wrap[%0d]: valid=%b f=%h cnt4=%0d, want valid=%b f=%h cnt4=%0d",
                     k, out_valid, f, op_count4, exp_valid, exp_r.f, cons_total[3:0]);
         end
         advance();
      end
      vectors++;
      if (op_count4 !== 4'(c0 + 17) || op_count !== 16'(c0 + 17)) begin
         miscompares++;
         $display("FAIL wrap_final: cnt4=%0d cnt=%0d, want cnt4=%0d cnt=%0d",
                  op_count4, op_count, 4'(c0 + 17), c0 + 17);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within 200000 time units");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_ops();
      test_back_to_back();
      test_backpressure();
      test_acc();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
